// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with a configurable frame, fed by a small write FIFO.
// Defining UART_TX_BREAK_EN adds the brk input and a BREAK state that holds the line low.
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int AW         = 2
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  input  logic                 clken,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 wr_en,
  input  logic                 par_en,
  input  logic                 par_odd,
`ifdef UART_TX_BREAK_EN
  input  logic                 brk,
`endif
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 fifo_full,
  output logic [AW:0]          fifo_cnt,
  output logic                 overflow
);

  localparam int              BW        = $clog2(DATA_BITS);
  localparam logic [BW-1:0]   LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0]   BIT_ZERO  = {BW{1'b0}};
  localparam logic [AW:0]     CNT_FULL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]     CNT_ZERO  = {(AW+1){1'b0}};
  localparam logic [AW-1:0]   PTR_ZERO  = {AW{1'b0}};
  localparam logic            STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
`ifdef UART_TX_BREAK_EN
    , BREAK = 3'd5
`endif
  } state_t;

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
    parity_bit = (^data) ^ odd;
  endfunction

  logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_r, rd_ptr_r;
  logic [AW:0]          cnt_r;
  logic                 ovf_r;
  logic                 push_s, pop_s, full_s;
  logic [DATA_BITS-1:0] head_s;

  state_t               state_r, state_nxt_s;
  logic                 tx_r, tx_nxt_s;
  logic [DATA_BITS-1:0] shift_r, shift_nxt_s;
  logic [BW-1:0]        bitpos_r, bitpos_nxt_s;
  logic                 stopcnt_r, stopcnt_nxt_s;
  logic                 par_en_r, par_en_nxt_s;
  logic                 par_bit_r, par_bit_nxt_s;

  assign full_s    = (cnt_r == CNT_FULL);
  assign push_s    = wr_en && !full_s;
  assign head_s    = mem_r[rd_ptr_r];

  assign tx        = tx_r;
  assign tx_busy   = (state_r != IDLE);
  assign fifo_full = full_s;
  assign fifo_cnt  = cnt_r;
  assign overflow  = ovf_r;

  // FIFO pointers, occupancy and the overflow pulse
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      cnt_r    <= CNT_ZERO;
      ovf_r    <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + 1'b1;
        2'b01:   cnt_r <= cnt_r - 1'b1;
        default: cnt_r <= cnt_r;
      endcase
      ovf_r <= wr_en && full_s;
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge CLK) begin
    if (push_s) mem_r[wr_ptr_r] <= din;
  end

  // Frame state register; reset parks the line high immediately
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      tx_r      <= 1'b1;
      shift_r   <= {DATA_BITS{1'b0}};
      bitpos_r  <= BIT_ZERO;
      stopcnt_r <= 1'b0;
      par_en_r  <= 1'b0;
      par_bit_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      tx_r      <= tx_nxt_s;
      shift_r   <= shift_nxt_s;
      bitpos_r  <= bitpos_nxt_s;
      stopcnt_r <= stopcnt_nxt_s;
      par_en_r  <= par_en_nxt_s;
      par_bit_r <= par_bit_nxt_s;
    end
  end

  // Next-state logic; parity is resolved at load so later par_* changes cannot leak in
  always_comb begin
    state_nxt_s   = state_r;
    tx_nxt_s      = tx_r;
    shift_nxt_s   = shift_r;
    bitpos_nxt_s  = bitpos_r;
    stopcnt_nxt_s = stopcnt_r;
    par_en_nxt_s  = par_en_r;
    par_bit_nxt_s = par_bit_r;
    pop_s         = 1'b0;
    case (state_r)
      IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (brk) begin
          state_nxt_s = BREAK;
        end else if (cnt_r != CNT_ZERO) begin
`else
        if (cnt_r != CNT_ZERO) begin
`endif
          pop_s         = 1'b1;
          shift_nxt_s   = head_s;
          par_en_nxt_s  = par_en;
          par_bit_nxt_s = parity_bit(head_s, par_odd);
          bitpos_nxt_s  = BIT_ZERO;
          state_nxt_s   = START;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (clken) begin
          tx_nxt_s    = 1'b0;
          state_nxt_s = DATA;
        end else begin
          state_nxt_s = START;
        end
      end
      DATA: begin
        if (clken) begin
          tx_nxt_s    = shift_r[0];
          shift_nxt_s = {1'b0, shift_r[DATA_BITS-1:1]};
          if (bitpos_r == LAST_BIT) begin
            stopcnt_nxt_s = 1'b0;
            state_nxt_s   = par_en_r ? PARITY : STOP;
          end else begin
            bitpos_nxt_s = bitpos_r + 1'b1;
          end
        end else begin
          state_nxt_s = DATA;
        end
      end
      PARITY: begin
        if (clken) begin
          tx_nxt_s    = par_bit_r;
          state_nxt_s = STOP;
        end else begin
          state_nxt_s = PARITY;
        end
      end
      STOP: begin
        if (clken) begin
          tx_nxt_s = 1'b1;
          if (stopcnt_r == STOP_LAST) begin
            state_nxt_s = IDLE;
          end else begin
            stopcnt_nxt_s = stopcnt_r + 1'b1;
          end
        end else begin
          state_nxt_s = STOP;
        end
      end
`ifdef UART_TX_BREAK_EN
      BREAK: begin
        if (clken) begin
          if (brk) begin
            tx_nxt_s = 1'b0;
          end else begin
            tx_nxt_s    = 1'b1;
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = BREAK;
        end
      end
`endif
      default: begin
        state_nxt_s = IDLE;
        tx_nxt_s    = 1'b1;
      end
    endcase
  end

endmodule
